// File: rtl/ps2_mouse_packet_decoder_if.sv
// PS/2 mouse decoder bus: serial data in, decoded packet state out.
// Latency: n/a (signal bundle only).
// Backpressure: none; consumers detect new packets via pkt_toggle.
interface ps2_mouse_packet_decoder_if #(
    parameter int CNT_W = 16,
    parameter int POS_W = 12,
    parameter int ERR_W = 8
);
    logic             Mouse_Data;
    logic             btn_l;
    logic             btn_r;
    logic             btn_m;
    logic [8:0]       dx;
    logic [8:0]       dy;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [CNT_W-1:0] click_count;
    logic             pkt_toggle;
    logic             frame_err;
    logic [ERR_W-1:0] err_count;

    // decoder side
    modport master (
        input  Mouse_Data,
        output btn_l, btn_r, btn_m, dx, dy, pos_x, pos_y,
        output click_count, pkt_toggle, frame_err, err_count
    );

    // pin driver / consumer side
    modport slave (
        output Mouse_Data,
        input  btn_l, btn_r, btn_m, dx, dy, pos_x, pos_y,
        input  click_count, pkt_toggle, frame_err, err_count
    );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse receiver: 11-bit frame deserialiser, 3-byte packet assembler, cursor/click tracker.
// Latency: outputs update on the falling Mouse_Clk edge that samples the stop bit of byte 2.
// Backpressure: none; outputs hold between packets, pkt_toggle flips once per accepted packet.
module ps2_mouse_packet_decoder #(
    parameter int CNT_W  = 16,
    parameter int POS_W  = 12,
    parameter int X_MAX  = 1023,
    parameter int Y_MAX  = 767,
    parameter int X_INIT = 512,
    parameter int Y_INIT = 384,
    parameter int ERR_W  = 8
) (
    input  logic Mouse_Clk,
    input  logic reset,
    ps2_mouse_packet_decoder_if.master bus
);
    localparam int PW = POS_W + 2;
    localparam logic signed [PW-1:0] X_MAX_S = PW'(X_MAX);
    localparam logic signed [PW-1:0] Y_MAX_S = PW'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par;
    logic [1:0]       byte_idx;
    // header byte without its sync bit: {yovf, xovf, ysign, xsign, m, r, l}
    logic [6:0]       hdr;
    logic [7:0]       xlo;

    logic             btn_l, btn_r, btn_m;
    logic [8:0]       dx, dy;
    logic [POS_W-1:0] pos_x, pos_y;
    logic [CNT_W-1:0] click_count;
    logic             pkt_toggle;
    logic             frame_err;
    logic [ERR_W-1:0] err_count;

    logic                 frame_ok;
    logic [8:0]           dx_n, dy_n;
    logic signed [PW-1:0] px_sum, py_sum;
    logic [POS_W-1:0]     px_next, py_next;
    logic                 l_press, r_press;
    logic [CNT_W-1:0]     cc_next;

    // Next-packet values, valid when the STOP edge of byte 2 is being sampled.
    always_comb begin
        frame_ok = (^{shreg, par}) & bus.Mouse_Data;
        dx_n     = hdr[5] ? 9'd0 : {hdr[3], xlo};
        dy_n     = hdr[6] ? 9'd0 : {hdr[4], shreg};
        px_sum   = $signed({2'b00, pos_x}) + $signed({{(PW-9){dx_n[8]}}, dx_n});
        py_sum   = $signed({2'b00, pos_y}) - $signed({{(PW-9){dy_n[8]}}, dy_n});
        px_next  = pos_x;
        py_next  = pos_y;
        if (px_sum < 0)             px_next = '0;
        else if (px_sum > X_MAX_S)  px_next = POS_W'(X_MAX);
        else                        px_next = px_sum[POS_W-1:0];
        if (py_sum < 0)             py_next = '0;
        else if (py_sum > Y_MAX_S)  py_next = POS_W'(Y_MAX);
        else                        py_next = py_sum[POS_W-1:0];
        // only 0->1 transitions against the previous packet count as clicks
        l_press  = hdr[0] & ~btn_l;
        r_press  = hdr[1] & ~btn_r;
        cc_next  = click_count;
        if (l_press && !r_press && click_count != '1)
            cc_next = click_count + 1'b1;
        else if (r_press && !l_press && click_count != '0)
            cc_next = click_count - 1'b1;
    end

    // Frame FSM, packet assembly and output registers, all on the falling PS/2 clock edge.
    always_ff @(negedge Mouse_Clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            byte_idx    <= '0;
            hdr         <= '0;
            xlo         <= '0;
            btn_l       <= 1'b0;
            btn_r       <= 1'b0;
            btn_m       <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            pos_x       <= POS_W'(X_INIT);
            pos_y       <= POS_W'(Y_INIT);
            click_count <= '0;
            pkt_toggle  <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.Mouse_Data) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    shreg   <= {bus.Mouse_Data, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state <= S_PARITY;
                end
                S_PARITY: begin
                    par   <= bus.Mouse_Data;
                    state <= S_STOP;
                end
                default: begin
                    state <= S_IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        byte_idx  <= '0;
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                    end else begin
                        frame_err <= 1'b0;
                        case (byte_idx)
                            2'd0: begin
                                // bit3 is the packet sync marker; anything else is mid-packet garbage
                                if (shreg[3]) begin
                                    hdr      <= {shreg[7:4], shreg[2:0]};
                                    byte_idx <= 2'd1;
                                end
                            end
                            2'd1: begin
                                xlo      <= shreg;
                                byte_idx <= 2'd2;
                            end
                            default: begin
                                byte_idx    <= 2'd0;
                                dx          <= dx_n;
                                dy          <= dy_n;
                                btn_l       <= hdr[0];
                                btn_r       <= hdr[1];
                                btn_m       <= hdr[2];
                                pos_x       <= px_next;
                                pos_y       <= py_next;
                                click_count <= cc_next;
                                pkt_toggle  <= ~pkt_toggle;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.btn_l       = btn_l;
    assign bus.btn_r       = btn_r;
    assign bus.btn_m       = btn_m;
    assign bus.dx          = dx;
    assign bus.dy          = dy;
    assign bus.pos_x       = pos_x;
    assign bus.pos_y       = pos_y;
    assign bus.click_count = click_count;
    assign bus.pkt_toggle  = pkt_toggle;
    assign bus.frame_err   = frame_err;
    assign bus.err_count   = err_count;
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Bench for the PS/2 mouse decoder: directed packet table, hand-built error/resync/reset sequences,
// then random frames checked against a byte-queue reference model.
// Data changes on rising Mouse_Clk; the DUT samples on falling; outputs are read #1 after rising.
module tb_ps2_mouse_packet_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ps2_mouse_packet_decoder_if #(.CNT_W(16), .POS_W(12), .ERR_W(8)) mif ();

    ps2_mouse_packet_decoder #(
        .CNT_W(16), .POS_W(12), .X_MAX(1023), .Y_MAX(767),
        .X_INIT(512), .Y_INIT(384), .ERR_W(8)
    ) dut (
        .Mouse_Clk(clk),
        .reset(reset),
        .bus(mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int l, r, m, dx, dy, px, py, cc;
    } vec_t;

    vec_t tbl[31];

    // reference model state
    int m_px, m_py, m_cc, m_err, m_ferr, m_tog, m_l, m_r, m_m, m_dx, m_dy;
    int m_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        mif.Mouse_Data = b;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        send_bit(1'b1);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 1'b0);
        send_frame(b1, 1'b0, 1'b0);
        send_frame(b2, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        mif.Mouse_Data = 1'b1;
        #2 reset = 1'b1;
        #20;
        chk("rst_pos_x", int'(mif.pos_x), 512);
        chk("rst_pos_y", int'(mif.pos_y), 384);
        chk("rst_click", int'(mif.click_count), 0);
        chk("rst_err", int'(mif.err_count), 0);
        chk("rst_tog", int'(mif.pkt_toggle), 0);
        chk("rst_btns", int'({mif.btn_l, mif.btn_r, mif.btn_m}), 0);
        chk("rst_ferr", int'(mif.frame_err), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Model: a frame stream, where good bytes are queued until three form a packet.
    task automatic model_frame(input int b, input bit good);
        int dxv, dyv, lp, rp;
        if (!good) begin
            m_ferr = 1;
            if (m_err < 255) m_err++;
            m_q.delete();
            return;
        end
        m_ferr = 0;
        if (m_q.size() == 0 && ((b >> 3) & 1) == 0) return;
        m_q.push_back(b);
        if (m_q.size() < 3) return;
        dxv = ((m_q[0] >> 6) & 1) ? 0 : (((m_q[0] >> 4) & 1) ? m_q[1] - 256 : m_q[1]);
        dyv = ((m_q[0] >> 7) & 1) ? 0 : (((m_q[0] >> 5) & 1) ? m_q[2] - 256 : m_q[2]);
        m_px = clampi(m_px + dxv, 1023);
        m_py = clampi(m_py - dyv, 767);
        lp = (m_q[0] & 1) && !m_l;
        rp = ((m_q[0] >> 1) & 1) && !m_r;
        if (lp && !rp) m_cc = (m_cc < 65535) ? m_cc + 1 : m_cc;
        else if (rp && !lp) m_cc = (m_cc > 0) ? m_cc - 1 : 0;
        m_l = m_q[0] & 1;
        m_r = (m_q[0] >> 1) & 1;
        m_m = (m_q[0] >> 2) & 1;
        m_dx = dxv;
        m_dy = dyv;
        m_tog ^= 1;
        m_q.delete();
    endtask

    task automatic compare_model();
        chk("rnd_pos_x", int'(mif.pos_x), m_px);
        chk("rnd_pos_y", int'(mif.pos_y), m_py);
        chk("rnd_click", int'(mif.click_count), m_cc);
        chk("rnd_err", int'(mif.err_count), m_err);
        chk("rnd_ferr", int'(mif.frame_err), m_ferr);
        chk("rnd_tog", int'(mif.pkt_toggle), m_tog);
        chk("rnd_btns", int'({mif.btn_m, mif.btn_r, mif.btn_l}), m_m * 4 + m_r * 2 + m_l);
        chk("rnd_dx", int'($signed(mif.dx)), m_dx);
        chk("rnd_dy", int'($signed(mif.dy)), m_dy);
    endtask

    initial begin
        int tog;
        logic [7:0] b;
        logic bp, bs;

        //         b0     b1     b2     l  r  m  dx    dy    px    py   cc
        tbl[0]  = '{8'h09, 8'h05, 8'h03, 1, 0, 0, 5,    3,    517,  381, 1};
        tbl[1]  = '{8'h09, 8'h05, 8'h03, 1, 0, 0, 5,    3,    522,  378, 1};
        tbl[2]  = '{8'h08, 8'h00, 8'h00, 0, 0, 0, 0,    0,    522,  378, 1};
        tbl[3]  = '{8'h0A, 8'h00, 8'h00, 0, 1, 0, 0,    0,    522,  378, 0};
        tbl[4]  = '{8'h08, 8'h00, 8'h00, 0, 0, 0, 0,    0,    522,  378, 0};
        tbl[5]  = '{8'h0A, 8'h00, 8'h00, 0, 1, 0, 0,    0,    522,  378, 0};
        tbl[6]  = '{8'h08, 8'h00, 8'h00, 0, 0, 0, 0,    0,    522,  378, 0};
        tbl[7]  = '{8'h09, 8'h00, 8'h00, 1, 0, 0, 0,    0,    522,  378, 1};
        tbl[8]  = '{8'h08, 8'h00, 8'h00, 0, 0, 0, 0,    0,    522,  378, 1};
        tbl[9]  = '{8'h09, 8'h00, 8'h00, 1, 0, 0, 0,    0,    522,  378, 2};
        tbl[10] = '{8'h0D, 8'h00, 8'h00, 1, 0, 1, 0,    0,    522,  378, 2};
        tbl[11] = '{8'h0B, 8'h00, 8'h00, 1, 1, 0, 0,    0,    522,  378, 1};
        tbl[12] = '{8'h08, 8'h00, 8'h00, 0, 0, 0, 0,    0,    522,  378, 1};
        tbl[13] = '{8'h0B, 8'h00, 8'h00, 1, 1, 0, 0,    0,    522,  378, 1};
        tbl[14] = '{8'h08, 8'hF6, 8'h00, 0, 0, 0, 246,  0,    768,  378, 1};
        tbl[15] = '{8'h08, 8'hF6, 8'h00, 0, 0, 0, 246,  0,    1014, 378, 1};
        tbl[16] = '{8'h08, 8'hF6, 8'h00, 0, 0, 0, 246,  0,    1023, 378, 1};
        tbl[17] = '{8'h18, 8'h00, 8'h00, 0, 0, 0, -256, 0,    767,  378, 1};
        tbl[18] = '{8'h18, 8'h00, 8'h00, 0, 0, 0, -256, 0,    511,  378, 1};
        tbl[19] = '{8'h18, 8'h00, 8'h00, 0, 0, 0, -256, 0,    255,  378, 1};
        tbl[20] = '{8'h18, 8'h00, 8'h00, 0, 0, 0, -256, 0,    0,    378, 1};
        tbl[21] = '{8'h48, 8'h7F, 8'h00, 0, 0, 0, 0,    0,    0,    378, 1};
        tbl[22] = '{8'h08, 8'h00, 8'h7F, 0, 0, 0, 0,    127,  0,    251, 1};
        tbl[23] = '{8'h08, 8'h00, 8'h7F, 0, 0, 0, 0,    127,  0,    124, 1};
        tbl[24] = '{8'h08, 8'h00, 8'h7F, 0, 0, 0, 0,    127,  0,    0,   1};
        tbl[25] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 0,    -256, 0,    256, 1};
        tbl[26] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 0,    -256, 0,    512, 1};
        tbl[27] = '{8'h28, 8'h00, 8'h00, 0, 0, 0, 0,    -256, 0,    767, 1};
        tbl[28] = '{8'h88, 8'h00, 8'h7F, 0, 0, 0, 0,    0,    0,    767, 1};
        tbl[29] = '{8'h38, 8'hFF, 8'hFF, 0, 0, 0, -1,   -1,   0,    767, 1};
        tbl[30] = '{8'h08, 8'h01, 8'h01, 0, 0, 0, 1,    1,    1,    766, 1};

        mif.Mouse_Data = 1'b1;
        do_reset();

        tog = 0;
        for (int i = 0; i < 31; i++) begin
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            tog ^= 1;
            chk($sformatf("v%0d_btn_l", i), int'(mif.btn_l), tbl[i].l);
            chk($sformatf("v%0d_btn_r", i), int'(mif.btn_r), tbl[i].r);
            chk($sformatf("v%0d_btn_m", i), int'(mif.btn_m), tbl[i].m);
            chk($sformatf("v%0d_dx", i), int'($signed(mif.dx)), tbl[i].dx);
            chk($sformatf("v%0d_dy", i), int'($signed(mif.dy)), tbl[i].dy);
            chk($sformatf("v%0d_pos_x", i), int'(mif.pos_x), tbl[i].px);
            chk($sformatf("v%0d_pos_y", i), int'(mif.pos_y), tbl[i].py);
            chk($sformatf("v%0d_click", i), int'(mif.click_count), tbl[i].cc);
            chk($sformatf("v%0d_tog", i), int'(mif.pkt_toggle), tog);
        end

        // bad parity on a header byte: flagged, counted, nothing committed
        send_frame(8'h09, 1'b1, 1'b0);
        chk("par_ferr", int'(mif.frame_err), 1);
        chk("par_err", int'(mif.err_count), 1);
        chk("par_tog", int'(mif.pkt_toggle), 1);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("par_rec_ferr", int'(mif.frame_err), 0);
        chk("par_rec_px", int'(mif.pos_x), 2);
        chk("par_rec_py", int'(mif.pos_y), 765);
        chk("par_rec_tog", int'(mif.pkt_toggle), 0);

        // bad stop bit on byte 1 must resync to a fresh header
        send_frame(8'h08, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1);
        chk("stop_ferr", int'(mif.frame_err), 1);
        chk("stop_err", int'(mif.err_count), 2);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("stop_rec_px", int'(mif.pos_x), 3);
        chk("stop_rec_py", int'(mif.pos_y), 764);
        chk("stop_rec_tog", int'(mif.pkt_toggle), 1);

        // header without sync bit is dropped
        send_frame(8'h00, 1'b0, 1'b0);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("sync_px", int'(mif.pos_x), 3);
        chk("sync_btn_l", int'(mif.btn_l), 1);
        chk("sync_click", int'(mif.click_count), 2);
        chk("sync_tog", int'(mif.pkt_toggle), 0);
        chk("sync_ferr", int'(mif.frame_err), 0);

        // reset in the middle of byte 1 discards the partial packet
        send_frame(8'h09, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_reset();
        send_pkt(8'h09, 8'h05, 8'h03);
        chk("mrst_px", int'(mif.pos_x), 517);
        chk("mrst_py", int'(mif.pos_y), 381);
        chk("mrst_click", int'(mif.click_count), 1);
        chk("mrst_tog", int'(mif.pkt_toggle), 1);
        chk("mrst_btn_l", int'(mif.btn_l), 1);

        // random frame stream against the reference model
        do_reset();
        m_px = 512; m_py = 384; m_cc = 0; m_err = 0; m_ferr = 0; m_tog = 0;
        m_l = 0; m_r = 0; m_m = 0; m_dx = 0; m_dy = 0;
        m_q.delete();
        for (int n = 0; n < 300; n++) begin
            b = 8'($urandom_range(0, 255));
            if (m_q.size() == 0 && $urandom_range(0, 9) != 0) b[3] = 1'b1;
            bp = 1'b0;
            bs = 1'b0;
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1'b1;
                else bs = 1'b1;
            end
            send_frame(b, bp, bs);
            model_frame(int'(b), !(bp || bs));
            compare_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
